// File: rtl/burst_pkg.sv
// burst_pkg: shared FSM state encoding and default burst/FIFO sizing for the burst read and write masters
package burst_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DRAIN, ST_DONE} burst_state_t;
   localparam int BURST_COUNT_DEF     = 8;
   localparam int FIFO_DEPTH_DEF      = 32;
   localparam int FIFO_DEPTH_LOG2_DEF = 5;
endpackage

// File: rtl/burst_read_stream_if.sv
// burst_read_stream_if: Avalon-MM burst read bus, control handshake and output word stream
// master modport: the read engine side; slave modport: memory, controller and stream consumer side
interface burst_read_stream_if #(
   parameter int ADDRESS_WIDTH     = 32,
   parameter int DATA_WIDTH        = 32,
   parameter int BYTE_ENABLE_WIDTH = DATA_WIDTH / 8,
   parameter int BURST_WIDTH       = 4,
   parameter int LENGTH_WIDTH      = 16
);
   import burst_pkg::*;
   logic [ADDRESS_WIDTH-1:0]     master_address;
   logic                         master_read;
   logic [BURST_WIDTH-1:0]       master_burstcount;
   logic [BYTE_ENABLE_WIDTH-1:0] master_byteenable;
   logic                         master_waitrequest;
   logic [DATA_WIDTH-1:0]        master_readdata;
   logic                         master_readdatavalid;
   logic                         ctrl_start;
   logic [ADDRESS_WIDTH-1:0]     ctrl_baseaddress;
   logic [LENGTH_WIDTH-1:0]      ctrl_length;
   logic                         ctrl_busy;
   logic                         ctrl_done;
   logic [DATA_WIDTH-1:0]        st_data;
   logic                         st_valid;
   logic                         st_ready;
   modport master (
      output master_address, master_read, master_burstcount, master_byteenable,
      input  master_waitrequest, master_readdata, master_readdatavalid,
      input  ctrl_start, ctrl_baseaddress, ctrl_length,
      output ctrl_busy, ctrl_done,
      output st_data, st_valid,
      input  st_ready
   );
   modport slave (
      input  master_address, master_read, master_burstcount, master_byteenable,
      output master_waitrequest, master_readdata, master_readdatavalid,
      output ctrl_start, ctrl_baseaddress, ctrl_length,
      input  ctrl_busy, ctrl_done,
      input  st_data, st_valid,
      output st_ready
   );
endinterface

// File: rtl/burst_read_fifo.sv
// burst_read_fifo: synchronous show-ahead FIFO; rdata is the head word whenever empty is low
// ports: wr/wdata push, rd pop (ignored when empty), rdata head, empty, used word count
module burst_read_fifo import burst_pkg::*; #(
   parameter int DATA_WIDTH      = 32,
   parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF,
   parameter int FIFO_DEPTH_LOG2 = $clog2(FIFO_DEPTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr,
   input  logic [DATA_WIDTH-1:0]    wdata,
   input  logic                     rd,
   output logic [DATA_WIDTH-1:0]    rdata,
   output logic                     empty,
   output logic [FIFO_DEPTH_LOG2:0] used
);
   localparam logic [FIFO_DEPTH_LOG2-1:0] LAST = FIFO_DEPTH_LOG2'(FIFO_DEPTH - 1);
   logic [DATA_WIDTH-1:0]      r_mem [FIFO_DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] r_wptr, r_rptr;
   logic [FIFO_DEPTH_LOG2:0]   r_used;
   logic                       w_rd;
   assign empty = r_used == '0;
   assign used  = r_used;
   assign rdata = r_mem[r_rptr];
   assign w_rd  = rd && !empty;
   always_ff @(posedge clk)
      if (wr) r_mem[r_wptr] <= wdata;
   // pointers wrap explicitly so depths that are not a power of two still work
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_used <= '0;
      end else begin
         if (wr) r_wptr <= r_wptr == LAST ? '0 : r_wptr + 1'b1;
         if (w_rd) r_rptr <= r_rptr == LAST ? '0 : r_rptr + 1'b1;
         r_used <= r_used + {{FIFO_DEPTH_LOG2{1'b0}}, wr} - {{FIFO_DEPTH_LOG2{1'b0}}, w_rd};
      end
endmodule

// File: rtl/burst_read_stream.sv
// burst_read_stream: Avalon-MM pipelined burst read master that streams fetched words out in order
// ports: clk, reset (async, active-high), bus (master modport: Avalon read bus, ctrl start/busy/done, st valid/ready stream)
module burst_read_stream import burst_pkg::*; #(
   parameter int ADDRESS_WIDTH     = 32,
   parameter int DATA_WIDTH        = 32,
   parameter int BYTE_ENABLE_WIDTH = DATA_WIDTH / 8,
   parameter int BURST_COUNT       = BURST_COUNT_DEF,
   parameter int BURST_WIDTH       = 4,
   parameter int LENGTH_WIDTH      = 16,
   parameter int FIFO_DEPTH        = FIFO_DEPTH_DEF,
   parameter int FIFO_DEPTH_LOG2   = FIFO_DEPTH_LOG2_DEF
) (
   input logic                 clk,
   input logic                 reset,
   burst_read_stream_if.master bus
);
   localparam int CW    = FIFO_DEPTH_LOG2 + 3;
   localparam int SHIFT = $clog2(BURST_COUNT);
   localparam logic [CW-1:0]              BURST_C = CW'(BURST_COUNT);
   localparam logic [CW-1:0]              DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [FIFO_DEPTH_LOG2:0]   BURST_O = (FIFO_DEPTH_LOG2 + 1)'(BURST_COUNT);
   localparam logic [BURST_WIDTH-1:0]     BURST_B = BURST_WIDTH'(BURST_COUNT);
   localparam logic [ADDRESS_WIDTH-1:0]   STRIDE  = ADDRESS_WIDTH'(BURST_COUNT * BYTE_ENABLE_WIDTH);
   burst_state_t             r_state;
   logic [LENGTH_WIDTH-1:0]  r_bursts;
   logic [FIFO_DEPTH_LOG2:0] r_outstanding;
   logic [FIFO_DEPTH_LOG2:0] w_used;
   logic [LENGTH_WIDTH-1:0]  w_len_bursts;
   logic [CW-1:0]            w_committed;
   logic                     w_accept, w_beat, w_pop, w_empty, w_credit, w_credit_next;
   assign w_accept     = bus.master_read && !bus.master_waitrequest;
   // beats with nothing outstanding are leftovers from before a reset and are dropped
   assign w_beat       = bus.master_readdatavalid && r_outstanding != '0;
   assign w_pop        = bus.st_valid && bus.st_ready;
   assign w_len_bursts = bus.ctrl_length >> SHIFT;
   assign w_committed  = CW'(w_used) + CW'(r_outstanding);
   assign w_credit     = w_committed + BURST_C <= DEPTH_C;
   // on an accept the burst just granted is not yet in r_outstanding, so reserve it too
   assign w_credit_next = w_committed + BURST_C + BURST_C <= DEPTH_C;
   assign bus.master_byteenable = '1;
   assign bus.st_valid = !w_empty;
   burst_read_fifo #(
      .DATA_WIDTH     (DATA_WIDTH),
      .FIFO_DEPTH     (FIFO_DEPTH),
      .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)
   ) u_fifo (
      .clk  (clk),
      .reset(reset),
      .wr   (w_beat),
      .wdata(bus.master_readdata),
      .rd   (w_pop),
      .rdata(bus.st_data),
      .empty(w_empty),
      .used (w_used)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_state               <= ST_IDLE;
         r_bursts              <= '0;
         r_outstanding         <= '0;
         bus.master_address    <= '0;
         bus.master_read       <= 1'b0;
         bus.master_burstcount <= '0;
         bus.ctrl_busy         <= 1'b0;
         bus.ctrl_done         <= 1'b0;
      end else begin
         r_outstanding <= r_outstanding + (w_accept ? BURST_O : '0) - {{FIFO_DEPTH_LOG2{1'b0}}, w_beat};
         bus.ctrl_done <= 1'b0;
         case (r_state)
            ST_IDLE:
               if (bus.ctrl_start) begin
                  bus.master_address <= bus.ctrl_baseaddress;
                  r_bursts           <= w_len_bursts;
                  bus.ctrl_busy      <= 1'b1;
                  if (w_len_bursts != '0) begin
                     r_state               <= ST_ISSUE;
                     bus.master_read       <= 1'b1;
                     bus.master_burstcount <= BURST_B;
                  end else
                     r_state <= ST_DONE;
               end
            ST_ISSUE:
               if (w_accept) begin
                  bus.master_address <= bus.master_address + STRIDE;
                  r_bursts           <= r_bursts - 1'b1;
                  if (r_bursts == LENGTH_WIDTH'(1) || !w_credit_next) begin
                     r_state               <= r_bursts == LENGTH_WIDTH'(1) ? ST_DRAIN : ST_WAIT;
                     bus.master_read       <= 1'b0;
                     bus.master_burstcount <= '0;
                  end
               end
            ST_WAIT:
               if (w_credit) begin
                  r_state               <= ST_ISSUE;
                  bus.master_read       <= 1'b1;
                  bus.master_burstcount <= BURST_B;
               end
            ST_DRAIN:
               if (r_outstanding == '0 && w_empty) r_state <= ST_DONE;
            ST_DONE: begin
               bus.ctrl_done <= 1'b1;
               bus.ctrl_busy <= 1'b0;
               r_state       <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
endmodule

// File: tb/tb_burst_read_stream.sv
// tb_burst_read_stream: directed self-checking bench for burst_read_stream with a burst-returning slave model
module tb_burst_read_stream;
   logic clk = 1'b0;
   logic reset;
   int checks = 0;
   int failures = 0;
   int edge_n = 0;
   int done_cnt = 0;
   int beat_cnt = 0;
   int st;
   bit read_seen = 0;
   logic [31:0] next_data = 0;
   logic [31:0] cmd_addr[$];
   logic [3:0]  cmd_bc[$];
   int          cmd_edge[$];
   logic [31:0] rx[$];
   int          sched[$];

   burst_read_stream_if bus ();
   burst_read_stream dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) edge_n++;

   // slave + monitor: decisions made mid-cycle for the coming edge; first beat two cycles after accept
   always @(negedge clk) begin
      if (bus.master_read) read_seen = 1;
      if (bus.master_read && !bus.master_waitrequest) begin
         cmd_addr.push_back(bus.master_address);
         cmd_bc.push_back(bus.master_burstcount);
         cmd_edge.push_back(edge_n + 1);
         st = edge_n + 3;
         if (sched.size() > 0 && sched[$] >= st) st = sched[$] + 1;
         for (int i = 0; i < 8; i++) sched.push_back(st + i);
      end
      if (bus.st_valid && bus.st_ready) rx.push_back(bus.st_data);
      if (bus.ctrl_done) done_cnt++;
      if (sched.size() > 0 && sched[0] == edge_n + 1) begin
         bus.master_readdatavalid = 1'b1;
         bus.master_readdata = next_data;
         next_data++;
         beat_cnt++;
         void'(sched.pop_front());
      end else begin
         bus.master_readdatavalid = 1'b0;
         bus.master_readdata = '0;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_logs();
      cmd_addr.delete();
      cmd_bc.delete();
      cmd_edge.delete();
      rx.delete();
      read_seen = 0;
   endtask

   task automatic start(input logic [31:0] base, input logic [15:0] len);
      bus.ctrl_baseaddress = base;
      bus.ctrl_length = len;
      bus.ctrl_start = 1'b1;
      tick(1);
      bus.ctrl_start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      int n = 0;
      while (bus.ctrl_done !== 1'b1 && n < budget) begin
         tick(1);
         n++;
      end
      ok = bus.ctrl_done === 1'b1;
   endtask

   task automatic test_reset();
      checks++;
      if ({bus.master_read, bus.ctrl_busy, bus.ctrl_done, bus.st_valid} !== 4'b0) begin
         failures++;
         $display("FAIL reset_flags read/busy/done/valid=%b required 0000", {bus.master_read, bus.ctrl_busy, bus.ctrl_done, bus.st_valid});
      end
      checks++;
      if (bus.master_address !== 32'h0 || bus.master_burstcount !== 4'h0) begin
         failures++;
         $display("FAIL reset_addr addr=%h bc=%0d required 0/0", bus.master_address, bus.master_burstcount);
      end
      checks++;
      if (bus.master_byteenable !== 4'hf) begin
         failures++;
         $display("FAIL byteenable got=%h required f", bus.master_byteenable);
      end
   endtask

   task automatic test_basic();
      bit ok;
      int bad = 0;
      int d0 = done_cnt;
      clear_logs();
      next_data = 3;
      bus.st_ready = 1'b1;
      start(32'h3800_0000, 16);
      checks++;
      if (bus.ctrl_busy !== 1'b1 || bus.master_read !== 1'b1 || bus.master_address !== 32'h3800_0000 || bus.master_burstcount !== 4'd8) begin
         failures++;
         $display("FAIL basic_first_cmd busy=%b read=%b addr=%h bc=%0d required 1/1/38000000/8", bus.ctrl_busy, bus.master_read, bus.master_address, bus.master_burstcount);
      end
      wait_done(200, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL basic_done_timeout done=%b required 1", bus.ctrl_done);
      end
      checks++;
      if (bus.ctrl_busy !== 1'b0) begin
         failures++;
         $display("FAIL basic_busy_at_done busy=%b required 0", bus.ctrl_busy);
      end
      tick(1);
      checks++;
      if (bus.ctrl_done !== 1'b0) begin
         failures++;
         $display("FAIL basic_done_width done=%b required 0", bus.ctrl_done);
      end
      tick(3);
      checks++;
      if (cmd_addr.size() != 2 || cmd_addr[0] !== 32'h3800_0000 || cmd_addr[1] !== 32'h3800_0020 || cmd_bc[0] !== 4'd8 || cmd_bc[1] !== 4'd8) begin
         failures++;
         $display("FAIL basic_cmds count=%0d required 2 at 38000000/38000020 bc 8", cmd_addr.size());
      end
      checks++;
      if (cmd_edge.size() != 2 || cmd_edge[1] - cmd_edge[0] != 1) begin
         failures++;
         $display("FAIL basic_back_to_back cmds=%0d required 2 on consecutive edges", cmd_edge.size());
      end
      for (int i = 0; i < 16; i++) if (i >= rx.size() || rx[i] !== 32'(3 + i)) bad++;
      checks++;
      if (rx.size() != 16 || bad != 0) begin
         failures++;
         $display("FAIL basic_stream words=%0d bad=%0d required 16/0", rx.size(), bad);
      end
      checks++;
      if (done_cnt - d0 != 1) begin
         failures++;
         $display("FAIL basic_done_count got=%0d required 1", done_cnt - d0);
      end
   endtask

   task automatic test_credit();
      bit ok;
      int bad = 0;
      clear_logs();
      next_data = 100;
      bus.st_ready = 1'b0;
      start(32'h0000_1000, 64);
      tick(60);
      checks++;
      if (cmd_addr.size() != 4 || bus.master_read !== 1'b0 || bus.ctrl_busy !== 1'b1) begin
         failures++;
         $display("FAIL credit_stall cmds=%0d read=%b busy=%b required 4/0/1", cmd_addr.size(), bus.master_read, bus.ctrl_busy);
      end
      checks++;
      if (bus.st_valid !== 1'b1 || bus.st_data !== 32'd100) begin
         failures++;
         $display("FAIL credit_head valid=%b data=%0d required 1/100", bus.st_valid, bus.st_data);
      end
      bus.st_ready = 1'b1;
      wait_done(500, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL credit_done_timeout done=%b required 1", bus.ctrl_done);
      end
      tick(2);
      for (int i = 0; i < 8; i++) if (i >= cmd_addr.size() || cmd_addr[i] !== 32'h1000 + 32'(32 * i)) bad++;
      checks++;
      if (cmd_addr.size() != 8 || bad != 0) begin
         failures++;
         $display("FAIL credit_cmds count=%0d bad=%0d required 8/0", cmd_addr.size(), bad);
      end
      bad = 0;
      for (int i = 0; i < 64; i++) if (i >= rx.size() || rx[i] !== 32'(100 + i)) bad++;
      checks++;
      if (rx.size() != 64 || bad != 0) begin
         failures++;
         $display("FAIL credit_stream words=%0d bad=%0d required 64/0", rx.size(), bad);
      end
   endtask

   task automatic test_waitrequest();
      bit ok;
      int bad = 0;
      clear_logs();
      next_data = 40;
      bus.master_waitrequest = 1'b1;
      start(32'h0000_2000, 8);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus.master_read !== 1'b1 || bus.master_address !== 32'h2000 || bus.master_burstcount !== 4'd8 || cmd_addr.size() != 0 || bus.st_valid !== 1'b0) begin
            failures++;
            $display("FAIL wait_hold cycle=%0d read=%b addr=%h bc=%0d cmds=%0d valid=%b required 1/2000/8/0/0", i, bus.master_read, bus.master_address, bus.master_burstcount, cmd_addr.size(), bus.st_valid);
         end
         tick(1);
      end
      bus.master_waitrequest = 1'b0;
      wait_done(100, ok);
      tick(2);
      for (int i = 0; i < 8; i++) if (i >= rx.size() || rx[i] !== 32'(40 + i)) bad++;
      checks++;
      if (!ok || cmd_addr.size() != 1 || cmd_addr[0] !== 32'h2000 || rx.size() != 8 || bad != 0) begin
         failures++;
         $display("FAIL wait_result done=%b cmds=%0d words=%0d bad=%0d required 1/1/8/0", ok, cmd_addr.size(), rx.size(), bad);
      end
   endtask

   task automatic test_zero_bursts();
      logic [15:0] lens [2] = '{16'd0, 16'd5};
      foreach (lens[k]) begin
         clear_logs();
         start(32'h0000_3000, lens[k]);
         checks++;
         if (bus.ctrl_busy !== 1'b1 || bus.ctrl_done !== 1'b0 || bus.master_read !== 1'b0) begin
            failures++;
            $display("FAIL zero_first len=%0d busy=%b done=%b read=%b required 1/0/0", lens[k], bus.ctrl_busy, bus.ctrl_done, bus.master_read);
         end
         tick(1);
         checks++;
         if (bus.ctrl_done !== 1'b1 || bus.ctrl_busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_done len=%0d done=%b busy=%b required 1/0", lens[k], bus.ctrl_done, bus.ctrl_busy);
         end
         tick(1);
         checks++;
         if (bus.ctrl_done !== 1'b0 || read_seen || cmd_addr.size() != 0) begin
            failures++;
            $display("FAIL zero_after len=%0d done=%b read_seen=%b cmds=%0d required 0/0/0", lens[k], bus.ctrl_done, read_seen, cmd_addr.size());
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int n = 0;
      int bad = 0;
      int b0 = beat_cnt;
      clear_logs();
      next_data = 500;
      bus.st_ready = 1'b0;
      start(32'h0000_4000, 8);
      while (beat_cnt - b0 < 3 && n < 50) begin
         tick(1);
         n++;
      end
      checks++;
      if (beat_cnt - b0 != 3 || bus.st_valid !== 1'b1) begin
         failures++;
         $display("FAIL rmid_pre beats=%0d valid=%b required 3/1", beat_cnt - b0, bus.st_valid);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({bus.master_read, bus.ctrl_busy, bus.ctrl_done, bus.st_valid} !== 4'b0 || bus.master_address !== 32'h0 || bus.master_burstcount !== 4'h0) begin
         failures++;
         $display("FAIL rmid_async read/busy/done/valid=%b addr=%h bc=%0d required 0000/0/0", {bus.master_read, bus.ctrl_busy, bus.ctrl_done, bus.st_valid}, bus.master_address, bus.master_burstcount);
      end
      tick(2);
      reset = 1'b0;
      bus.st_ready = 1'b1;
      n = 0;
      while (sched.size() > 0 && n < 40) begin
         tick(1);
         if (bus.st_valid !== 1'b0) bad++;
         n++;
      end
      tick(2);
      checks++;
      if (bad != 0 || rx.size() != 0 || beat_cnt - b0 != 8) begin
         failures++;
         $display("FAIL rmid_stale valid_cycles=%0d words=%0d beats=%0d required 0/0/8", bad, rx.size(), beat_cnt - b0);
      end
      clear_logs();
      next_data = 600;
      start(32'h0000_5000, 8);
      wait_done(100, ok);
      tick(2);
      bad = 0;
      for (int i = 0; i < 8; i++) if (i >= rx.size() || rx[i] !== 32'(600 + i)) bad++;
      checks++;
      if (!ok || cmd_addr.size() != 1 || cmd_addr[0] !== 32'h5000 || rx.size() != 8 || bad != 0) begin
         failures++;
         $display("FAIL rmid_restart done=%b cmds=%0d words=%0d bad=%0d required 1/1/8/0", ok, cmd_addr.size(), rx.size(), bad);
      end
   endtask

   task automatic test_ignore_start();
      bit ok;
      int bad = 0;
      int d0 = done_cnt;
      clear_logs();
      next_data = 700;
      bus.st_ready = 1'b1;
      start(32'h0000_6000, 16);
      tick(2);
      start(32'h0000_7000, 64);
      wait_done(200, ok);
      tick(3);
      for (int i = 0; i < 16; i++) if (i >= rx.size() || rx[i] !== 32'(700 + i)) bad++;
      checks++;
      if (!ok || cmd_addr.size() != 2 || cmd_addr[0] !== 32'h6000 || cmd_addr[1] !== 32'h6020) begin
         failures++;
         $display("FAIL ignore_cmds done=%b cmds=%0d required 1/2 at 6000/6020", ok, cmd_addr.size());
      end
      checks++;
      if (rx.size() != 16 || bad != 0 || done_cnt - d0 != 1 || bus.ctrl_busy !== 1'b0) begin
         failures++;
         $display("FAIL ignore_stream words=%0d bad=%0d dones=%0d busy=%b required 16/0/1/0", rx.size(), bad, done_cnt - d0, bus.ctrl_busy);
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.master_waitrequest = 1'b0;
      bus.ctrl_start = 1'b0;
      bus.ctrl_baseaddress = '0;
      bus.ctrl_length = '0;
      bus.st_ready = 1'b0;
      tick(2);
      test_reset();
      reset = 1'b0;
      tick(1);
      test_basic();
      test_credit();
      test_waitrequest();
      test_zero_bursts();
      test_reset_mid();
      test_ignore_start();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/burst_read_stream.md
# burst_read_stream

Avalon-MM pipelined burst read master feeding a valid/ready word stream. It is the read-side companion of the SDRAM burst write master. Given a base address and a word count, it fetches memory in fixed-size bursts into an internal FIFO and presents the words in order on a stream port. New bursts are issued only when the FIFO has room for the whole burst, so `master_readdatavalid` is never back-pressured.

## Interface
- `ADDRESS_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, word width
- `BYTE_ENABLE_WIDTH`, 4, `DATA_WIDTH/8`; byte stride per word
- `BURST_COUNT`, 8, words per burst; power of 2, 2..128
- `BURST_WIDTH`, 4, width of `master_burstcount`; must hold `BURST_COUNT`
- `LENGTH_WIDTH`, 16, width of `ctrl_length`
- `FIFO_DEPTH`, 32, FIFO words; multiple of `BURST_COUNT`, ≥ 2×`BURST_COUNT`
- `FIFO_DEPTH_LOG2`, 5

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `master_address`  out  `ADDRESS_WIDTH`  burst start byte address
- `master_read`  out  1  read command
- `master_burstcount`  out  `BURST_WIDTH`  constant `BURST_COUNT` while `master_read` is high
- `master_byteenable`  out  `BYTE_ENABLE_WIDTH`  all ones
- `master_waitrequest`  in  1  slave stall
- `master_readdata`  in  `DATA_WIDTH`  return data
- `master_readdatavalid`  in  1  return data strobe
- `ctrl_start`  in  1  one-cycle start pulse
- `ctrl_baseaddress`  in  `ADDRESS_WIDTH`  start address, sampled on start
- `ctrl_length`  in  `LENGTH_WIDTH`  words to read, sampled on start
- `ctrl_busy`  out  1  transfer in progress
- `ctrl_done`  out  1  one-cycle completion pulse
- `st_data`  out  `DATA_WIDTH`  FIFO head word
- `st_valid`  out  1  FIFO not empty
- `st_ready`  in  1  consumer accepts

## Operation
- Reset values: `master_address` 0, `master_read` 0, `master_burstcount` 0, `ctrl_busy` 0, `ctrl_done` 0, `st_valid` 0. FIFO is emptied and all counters are cleared.
- Number of bursts = `ctrl_length` / `BURST_COUNT`, truncated. Remainder words are never read.
- FSM states:
  - IDLE: on `ctrl_start`, latch address and burst count. Go to ISSUE if bursts > 0, else to DONE.
  - ISSUE: assert `master_read`. The command is accepted when `master_read` && !`master_waitrequest`. On accept, address += `BURST_COUNT`×`BYTE_ENABLE_WIDTH` and remaining bursts decrement. If none remain, go to DRAIN. Otherwise, if credit is unavailable, drop `master_read` and go to WAIT.
  - WAIT: hold until credit is available, then go to ISSUE.
  - DRAIN: wait until outstanding = 0, FIFO is empty and the last stream word has been accepted, then go to DONE.
  - DONE: pulse `ctrl_done` for one cycle, drop `ctrl_busy`, go to IDLE.
- Credit: fifo_used + outstanding + `BURST_COUNT` ≤ `FIFO_DEPTH`.
  - Outstanding adds `BURST_COUNT` on command accept and subtracts 1 per `master_readdatavalid`. Both may occur in the same cycle; apply the net change.
- `master_readdatavalid` while outstanding = 0 (stale data after a reset) is discarded and does not write the FIFO.
- `ctrl_start` while `ctrl_busy` is ignored.
- Stream: `st_valid` = FIFO not empty; `st_data` = head (show-ahead). A word is popped when `st_valid` && `st_ready`. A push and a pop in the same cycle leave fifo_used unchanged.
- Address arithmetic wraps modulo 2^`ADDRESS_WIDTH`.

## Timing
- `ctrl_start` sampled at edge 0 → `ctrl_busy` = 1 and `master_read` = 1, with `master_address` = base, after edge 0.
- While `master_waitrequest` is high, `master_read`, `master_address` and `master_burstcount` stay stable.
- Back-to-back bursts: if credit allows, the next command is driven in the cycle immediately after an accept. There is no idle gap.
- `master_readdatavalid` at edge N → word visible on `st_valid`/`st_data` after edge N (registered FIFO write, show-ahead read). A word written at edge N is poppable at edge N+1.
- Zero bursts: `ctrl_done` is high in the second cycle after start, with no command issued.
- `ctrl_done` is high for exactly one cycle and coincides with `ctrl_busy` falling.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). The FIFO contents are lost.

## Structure
- Shared package (`burst_pkg`): the FSM state encoding (IDLE, ISSUE, WAIT, DRAIN, DONE) and default burst and FIFO constants. The write master uses the same package.
- Sub-module `burst_read_fifo`: synchronous show-ahead FIFO with ports `wr`, `wdata`, `rd`, `rdata`, `empty` and `used[FIFO_DEPTH_LOG2:0]`. It is parameterised by `DATA_WIDTH` and `FIFO_DEPTH`.

## Test plan
- Base 0x38000000, length 16, `waitrequest` 0, slave returns 3..18 two cycles after each accept, `st_ready` 1 → commands at 0x38000000 and 0x38000020 with burstcount 8; stream 3..18 in order; one `ctrl_done`.
- Length 64, `FIFO_DEPTH` 32, `st_ready` 0 → exactly 4 commands, then `master_read` stays low. After `st_ready` rises, the remaining 4 bursts are issued and all 64 words stream out in order.
- `waitrequest` high for 5 cycles on the first command → address, read and burstcount are held stable for 5 cycles; outstanding stays 0 until the accept.
- Length 0 and length 5 → no `master_read`; `ctrl_done` pulses in the second cycle after start.
- Reset asserted after 3 of 8 data beats, and the slave keeps sending 5 beats → all outputs are at reset values, `st_valid` stays 0 (stale beats discarded), and a following start reads correctly.
- `ctrl_start` pulsed mid-transfer with a different base → ignored; the original transfer completes unchanged.
